// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM among N_REQ requesters with a req/gnt handshake and read-data return.
// Optional macro SRAM_ARB_FIXED_PRI_EN selects fixed priority (lowest index wins) instead of round-robin.
module sram_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned BW_DATA = 64,
  parameter int unsigned BW_ADDR = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ-1:0]           i_we,
  input  logic [N_REQ*BW_ADDR-1:0]   i_addr,
  input  logic [N_REQ*BW_DATA-1:0]   i_wdata,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [N_REQ-1:0]           o_rvalid,
  output logic [BW_DATA-1:0]         o_rdata,
  output logic                       o_busy,
  output logic [BW_ADDR-1:0]         o_sram_addr,
  output logic [BW_DATA-1:0]         o_sram_data,
  output logic                       o_sram_cen,
  output logic                       o_sram_wen,
  output logic                       o_sram_oen,
  input  logic [BW_DATA-1:0]         i_sram_data
);

  localparam int unsigned W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CMD    = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [W_IDX-1:0]     w_q, w_d;
  logic                 we_q, we_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]     rvalid_q, rvalid_d;
  logic [BW_DATA-1:0]   rdata_q, rdata_d;
  logic [BW_DATA-1:0]   sram_data_q, sram_data_d;
  logic [BW_ADDR-1:0]   sram_addr_q, sram_addr_d;
  logic                 busy_q, busy_d;
  logic                 cen_q, cen_d;
  logic                 wen_q, wen_d;
  logic                 oen_q, oen_d;

  logic                 any_req_c;
  logic [W_IDX-1:0]     win_c;
  logic                 sel_we_c;
  logic [BW_ADDR-1:0]   sel_addr_c;
  logic [BW_DATA-1:0]   sel_data_c;

`ifdef SRAM_ARB_FIXED_PRI_EN
  // Lowest requesting index wins; reverse scan lets the lowest hit overwrite.
  always_comb begin
    any_req_c = 1'b0;
    win_c     = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (i_req[W_IDX'(i)]) begin
        any_req_c = 1'b1;
        win_c     = W_IDX'(i);
      end
    end
  end
`else
  logic [W_IDX-1:0]     ptr_q, ptr_d;
  int unsigned          idx_c;

  // Search from ptr upward with wrap; reverse scan leaves the first hit in search order.
  always_comb begin
    any_req_c = 1'b0;
    win_c     = '0;
    idx_c     = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      idx_c = (32'(ptr_q) + 32'(i)) % N_REQ;
      if (i_req[W_IDX'(idx_c)]) begin
        any_req_c = 1'b1;
        win_c     = W_IDX'(idx_c);
      end
    end
  end
`endif

  // Route the winner's command fields.
  always_comb begin
    sel_we_c   = 1'b0;
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (win_c == W_IDX'(k)) begin
        sel_we_c   = i_we[k];
        sel_addr_c = i_addr[k*BW_ADDR +: BW_ADDR];
        sel_data_c = i_wdata[k*BW_DATA +: BW_DATA];
      end
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    we_d        = we_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    cen_d       = 1'b0;
    wen_d       = 1'b0;
    oen_d       = 1'b0;
`ifndef SRAM_ARB_FIXED_PRI_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          state_d     = S_CMD;
          w_d         = win_c;
          we_d        = sel_we_c;
          sram_addr_d = sel_addr_c;
          sram_data_d = sel_data_c;
          gnt_d       = N_REQ'(1) << win_c;
          cen_d       = 1'b1;
          wen_d       = sel_we_c;
          oen_d       = ~sel_we_c;
`ifndef SRAM_ARB_FIXED_PRI_EN
          ptr_d       = (32'(win_c) == N_REQ - 1) ? '0 : W_IDX'(32'(win_c) + 32'd1);
`endif
        end
      end
      S_CMD: begin
        state_d = we_q ? S_IDLE : S_RDWAIT;
        oen_d   = ~we_q;
      end
      S_RDWAIT: begin
        state_d  = S_IDLE;
        rdata_d  = i_sram_data;
        rvalid_d = N_REQ'(1) << w_q;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      we_q        <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      busy_q      <= 1'b0;
      cen_q       <= 1'b0;
      wen_q       <= 1'b0;
      oen_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      we_q        <= we_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      busy_q      <= busy_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      oen_q       <= oen_d;
    end
  end

`ifndef SRAM_ARB_FIXED_PRI_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`endif

  assign o_gnt       = gnt_q;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = busy_q;
  assign o_sram_addr = sram_addr_q;
  assign o_sram_data = sram_data_q;
  assign o_sram_cen  = cen_q;
  assign o_sram_wen  = wen_q;
  assign o_sram_oen  = oen_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed table, multi-cycle corner sequences, randomized traffic vs model.
module tb_sram_arbiter;
  localparam int unsigned NR = 3;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 6;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    we = '0;
  logic [NR*AW-1:0] addr = '0;
  logic [NR*DW-1:0] wdata = '0;
  logic [NR-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata, sram_wd, sram_rd;
  logic             busy, cen, wen, oen;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_mem [64];

  int n_cmp = 0;
  int n_err = 0;
  int model_ptr = 0;
  logic [DW-1:0] model_mem [64];

  always #5 clk = ~clk;

  sram_arbiter #(.N_REQ(NR), .BW_DATA(DW), .BW_ADDR(AW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_busy(busy),
    .o_sram_addr(sram_addr), .o_sram_data(sram_wd), .o_sram_cen(cen), .o_sram_wen(wen),
    .o_sram_oen(oen), .i_sram_data(sram_rd)
  );

  // Single-port SRAM: write or registered read when enabled.
  always @(posedge clk) begin
    if (cen) begin
      if (wen) sram_mem[sram_addr] <= sram_wd;
      else     sram_rd <= sram_mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (gnt == '0 && cycles < 8);
    if (gnt == '0) begin
      n_cmp++;
      n_err++;
      $display("FAIL gnt_timeout: got no grant within %0d cycles", cycles);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    req  = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_ptr = 0;
  endtask

  // One isolated access by requester k; checks handshake, SRAM pins and read timing.
  task automatic access(input int k, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd);
    int n;
    logic [NR-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    req[k] = 1'b1;
    we[k]  = w;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
    wait_gnt(n);
    check("acc_gnt", gnt, oh);
    check("acc_cen", cen, 1);
    check("acc_wen", wen, w);
    check("acc_oen", oen, !w);
    check("acc_addr", sram_addr, a);
    if (w) check("acc_wdata", sram_wd, d);
    req[k] = 1'b0;
    model_ptr = (k + 1) % NR;
    rd = '0;
    if (!w) begin
      @(negedge clk);
      check("acc_rdwait_rvalid", rvalid, 0);
      check("acc_rdwait_cen", cen, 0);
      check("acc_rdwait_oen", oen, 1);
      check("acc_rdwait_busy", busy, 1);
      @(negedge clk);
      check("acc_rvalid", rvalid, oh);
      check("acc_idle_busy", busy, 0);
      rd = rdata;
    end else begin
      @(negedge clk);
      check("acc_wr_idle_busy", busy, 0);
      check("acc_wr_rvalid", rvalid, 0);
    end
  endtask

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vt [10];

  initial begin
    int n, w, idx;
    int g_cyc, r_cyc, arb_cyc, busy_end;
    logic [NR-1:0] g_vec, r_vec, eg, er;
    logic [NR-1:0] exp3 [4];
    logic g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data, r_data, rd, last_rd, d;

    vt[0] = {1'b1, 6'h2A, 64'hDEAD_BEEF_0123_4567, 64'h0};
    vt[1] = {1'b0, 6'h2A, 64'h0, 64'hDEAD_BEEF_0123_4567};
    vt[2] = {1'b1, 6'h05, 64'h1, 64'h0};
    vt[3] = {1'b1, 6'h15, 64'h2, 64'h0};
    vt[4] = {1'b1, 6'h25, 64'h3, 64'h0};
    vt[5] = {1'b1, 6'h35, 64'h4, 64'h0};
    vt[6] = {1'b0, 6'h05, 64'h0, 64'h1};
    vt[7] = {1'b0, 6'h15, 64'h0, 64'h2};
    vt[8] = {1'b0, 6'h25, 64'h0, 64'h3};
    vt[9] = {1'b0, 6'h35, 64'h0, 64'h4};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_data", sram_wd, 0);
    check("rst_cen", cen, 0);
    check("rst_wen", wen, 0);
    check("rst_oen", oen, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_gnt", gnt, 0);
    check("idle_cen", cen, 0);

    // Two requesters held high continuously
`ifdef SRAM_ARB_FIXED_PRI_EN
    exp3 = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp3 = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
    we = 3'b011;
    addr[0 +: AW] = 6'h10;
    addr[AW +: AW] = 6'h11;
    req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(n);
      check("rr_gnt", gnt, exp3[i]);
      if (i > 0) check("rr_write_spacing", n, 2);
    end
    req = '0;
    @(negedge clk);

    // Directed write/read table on requester 0
    last_rd = '0;
    for (int i = 0; i < 10; i++) begin
      access(0, vt[i].we, vt[i].addr, vt[i].wdata, rd);
      if (vt[i].we) check("tbl_rdata_hold", rdata, last_rd);
      else begin
        check("tbl_rdata", rd, vt[i].exp_rdata);
        last_rd = vt[i].exp_rdata;
      end
    end

    // Reset during RDWAIT drops the read and clears the pointer
    we[0] = 1'b0;
    addr[0 +: AW] = 6'h05;
    req[0] = 1'b1;
    wait_gnt(n);
    check("rdw_gnt", gnt, 3'b001);
    req[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rdw_rst_rvalid", rvalid, 0);
    check("rdw_rst_busy", busy, 0);
    check("rdw_rst_oen", oen, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rdw_no_rvalid", rvalid, 0);
    end
    rstn = 1'b1;
    we = 3'b011;
    req = 3'b011;
    wait_gnt(n);
    check("rdw_post_first", gnt, 3'b001);
    req[0] = 1'b0;
    wait_gnt(n);
    check("rdw_post_second", gnt, 3'b010);
    req = '0;
    @(negedge clk);

    // Arbitration in the same IDLE cycle as o_rvalid
    we[1] = 1'b0;
    addr[AW +: AW] = 6'h2A;
    req[1] = 1'b1;
    wait_gnt(n);
    check("ovl_gnt1", gnt, 3'b010);
    req[1] = 1'b0;
    we[0] = 1'b1;
    addr[0 +: AW] = 6'h3F;
    wdata[0 +: DW] = 64'h55;
    req[0] = 1'b1;
    @(negedge clk);
    check("ovl_rdwait_gnt", gnt, 0);
    @(negedge clk);
    check("ovl_rvalid1", rvalid, 3'b010);
    check("ovl_rdata", rdata, 64'hDEAD_BEEF_0123_4567);
    check("ovl_idle_gnt", gnt, 0);
    @(negedge clk);
    check("ovl_gnt0", gnt, 3'b001);
    req[0] = 1'b0;
    @(negedge clk);

    // Fill the whole memory so the model knows every location
    do_reset();
    for (int i = 0; i < 64; i++) begin
      d = {$urandom, $urandom};
      access(int'($urandom_range(NR - 1)), 1'b1, AW'(i), d, rd);
      model_mem[i] = d;
    end

    // Randomized multi-requester traffic vs scheduling model
    g_cyc = -10; r_cyc = -10; busy_end = -10; arb_cyc = 0;
    g_vec = '0; r_vec = '0; g_we = 1'b0; g_addr = '0; g_data = '0; r_data = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      eg = (cyc == g_cyc) ? g_vec : '0;
      er = (cyc == r_cyc) ? r_vec : '0;
      check("rnd_gnt", gnt, eg);
      check("rnd_rvalid", rvalid, er);
      check("rnd_busy", busy, (cyc >= g_cyc && cyc < busy_end));
      check("rnd_cen", cen, (cyc == g_cyc));
      if (cyc == g_cyc) begin
        check("rnd_wen", wen, g_we);
        check("rnd_oen", oen, !g_we);
        check("rnd_addr", sram_addr, g_addr);
        if (g_we) check("rnd_wdata", sram_wd, g_data);
      end
      if (cyc == r_cyc) check("rnd_rdata", rdata, r_data);
      for (int k = 0; k < NR; k++) begin
        if (cyc == g_cyc && g_vec[k]) req[k] = 1'b0;
        if (!req[k] && cyc < 1450 && $urandom_range(2) == 0) begin
          req[k] = 1'b1;
          we[k]  = 1'($urandom);
          addr[k*AW +: AW]  = AW'($urandom);
          wdata[k*DW +: DW] = {$urandom, $urandom};
        end
      end
      if (cyc == arb_cyc) begin
        w = -1;
        for (int i = 0; i < NR; i++) begin
`ifdef SRAM_ARB_FIXED_PRI_EN
          idx = i;
`else
          idx = (model_ptr + i) % NR;
`endif
          if (w < 0 && req[idx]) w = idx;
        end
        if (w < 0) arb_cyc = cyc + 1;
        else begin
          g_cyc  = cyc + 1;
          g_vec  = '0;
          g_vec[w] = 1'b1;
          g_we   = we[w];
          g_addr = addr[w*AW +: AW];
          g_data = wdata[w*DW +: DW];
          model_ptr = (w + 1) % NR;
          if (g_we) begin
            model_mem[g_addr] = g_data;
            arb_cyc  = cyc + 2;
            busy_end = cyc + 2;
          end else begin
            r_cyc    = cyc + 3;
            r_vec    = g_vec;
            r_data   = model_mem[g_addr];
            arb_cyc  = cyc + 3;
            busy_end = cyc + 3;
          end
        end
      end
      @(negedge clk);
    end
    check("rnd_drained_req", req, 0);
    check("rnd_drained_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
